// File: rtl/pce_video_pkg.sv
// Shared video types for the VCE output path: RGB pixel struct, reader states
// and default line geometry.
package pce_video_pkg;

    localparam int unsigned PCE_MAX_WIDTH = 512;
    localparam int unsigned PCE_PIXEL_W   = 8;

    typedef struct packed {
        logic [PCE_PIXEL_W-1:0] r;
        logic [PCE_PIXEL_W-1:0] g;
        logic [PCE_PIXEL_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_FETCH  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_e;

    // Halve every channel (logical shift, floor) for a dimmed scanline
    function automatic rgb_t rgb_dim(input rgb_t p);
        rgb_t d;
        d.r = p.r >> 1;
        d.g = p.g >> 1;
        d.b = p.b >> 1;
        return d;
    endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Two-bank line store: one write port, one synchronous read port with a
// 1-cycle latency; the read register holds when no read is issued.
module line_bank_ram
    import pce_video_pkg::*;
#(
    parameter  int unsigned MAX_WIDTH = PCE_MAX_WIDTH,
    localparam int unsigned WADDR_W   = $clog2(MAX_WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_we,
    input  logic               i_wr_bank,
    input  logic [WADDR_W-1:0] i_wr_addr,
    input  rgb_t               i_wr_data,
    input  logic               i_re,
    input  logic               i_rd_bank,
    input  logic [WADDR_W-1:0] i_rd_addr,
    output rgb_t               o_rd_data
);

    rgb_t r_mem [2][MAX_WIDTH];
    rgb_t r_rd_data;

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
        end
    end

    // Read register only advances on an issued read so a stalled consumer sees stable data
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (i_re) begin
            r_rd_data <= r_mem[i_rd_bank][i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vce_line_doubler.sv
// Captures VCE scanlines into a ping-pong buffer and replays each one twice as a
// valid/ready stream. Optional SCANLINE_DIM_EN halves the second pass.
module vce_line_doubler
    import pce_video_pkg::*;
#(
    parameter  int unsigned MAX_WIDTH = PCE_MAX_WIDTH,
    parameter  int unsigned PIXEL_W   = PCE_PIXEL_W,
    localparam int unsigned WADDR_W   = $clog2(MAX_WIDTH),
    localparam int unsigned LEN_W     = WADDR_W + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic [PIXEL_W-1:0] vid_r,
    input  logic [PIXEL_W-1:0] vid_g,
    input  logic [PIXEL_W-1:0] vid_b,
    input  logic               hsync_n,
    input  logic               vsync_n,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIXEL_W-1:0] out_r,
    output logic [PIXEL_W-1:0] out_g,
    output logic [PIXEL_W-1:0] out_b,
    output logic               out_sol,
    output logic               out_eol,
    output logic               out_sof,
    output logic               overflow,
    output logic [LEN_W-1:0]   line_width
);

    logic             r_hs_prev;
    logic             r_vs_prev;
    logic             r_wr_bank;
    logic [LEN_W-1:0] r_wr_x;
    logic             r_frame_pending;
    logic             r_overflow;
    logic [LEN_W-1:0] r_line_width;

    rd_state_e        r_state;
    logic             r_pass;
    logic [WADDR_W-1:0] r_x;
    logic [LEN_W-1:0] r_rd_len;
    logic             r_rd_bank;
    logic             r_rd_sof;
    logic             r_out_valid;
    logic             r_sol;
    logic             r_eol;
    logic             r_sof;

    logic             w_hs_fall;
    logic             w_vs_fall;
    logic             w_line_done;
    logic             w_handoff;
    logic             w_pix_ok;
    logic             w_we;
    rgb_t             w_wr_data;
    rgb_t             w_rd_data;
    rgb_t             w_pix;

    rd_state_e        w_state_nxt;
    logic             w_pass_nxt;
    logic [WADDR_W-1:0] w_x_nxt;
    logic             w_re;
    logic [WADDR_W-1:0] w_rd_addr;
    logic             w_last;
    logic             w_valid_nxt;

    assign w_hs_fall   = r_hs_prev & ~hsync_n;
    assign w_vs_fall   = r_vs_prev & ~vsync_n;
    assign w_line_done = w_hs_fall & ~w_vs_fall & (r_wr_x != '0);
    // A reader finishing its last transfer this cycle is still busy
    assign w_handoff   = w_line_done & (r_state == RD_IDLE);
    assign w_pix_ok    = pix_valid & hsync_n & vsync_n;
    assign w_we        = w_pix_ok & (r_wr_x < LEN_W'(MAX_WIDTH));
    assign w_wr_data   = '{r: vid_r, g: vid_g, b: vid_b};

    line_bank_ram #(
        .MAX_WIDTH (MAX_WIDTH)
    ) u_ram (
        .clock     (clock),
        .reset     (reset),
        .i_we      (w_we),
        .i_wr_bank (r_wr_bank),
        .i_wr_addr (r_wr_x[WADDR_W-1:0]),
        .i_wr_data (w_wr_data),
        .i_re      (w_re),
        .i_rd_bank (r_rd_bank),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Writer: sync edge detect, pixel capture and line hand-off / drop
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hs_prev       <= 1'b1;
            r_vs_prev       <= 1'b1;
            r_wr_bank       <= 1'b0;
            r_wr_x          <= '0;
            r_frame_pending <= 1'b1;
            r_overflow      <= 1'b0;
            r_line_width    <= '0;
        end else begin
            r_hs_prev <= hsync_n;
            r_vs_prev <= vsync_n;
            if (w_vs_fall) begin
                r_wr_x          <= '0;
                r_frame_pending <= 1'b1;
            end else if (w_line_done) begin
                r_wr_x <= '0;
                if (w_handoff) begin
                    r_wr_bank       <= ~r_wr_bank;
                    r_frame_pending <= 1'b0;
                    r_line_width    <= r_wr_x;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (w_pix_ok && (r_wr_x != LEN_W'(MAX_WIDTH))) begin
                r_wr_x <= r_wr_x + LEN_W'(1);
            end
        end
    end

    assign w_last = ({1'b0, r_x} == (r_rd_len - LEN_W'(1)));

    // Reader next-state: prefetch the next address on every accepted transfer
    always_comb begin
        w_state_nxt = r_state;
        w_pass_nxt  = r_pass;
        w_x_nxt     = r_x;
        w_re        = 1'b0;
        w_rd_addr   = r_x;
        case (r_state)
            RD_IDLE: begin
                if (w_handoff) begin
                    w_state_nxt = RD_FETCH;
                    w_pass_nxt  = 1'b0;
                    w_x_nxt     = '0;
                end
            end
            RD_FETCH: begin
                w_re        = 1'b1;
                w_rd_addr   = '0;
                w_x_nxt     = '0;
                w_state_nxt = RD_STREAM;
            end
            RD_STREAM: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_x_nxt = '0;
                        if (!r_pass) begin
                            w_pass_nxt  = 1'b1;
                            w_state_nxt = RD_FETCH;
                        end else begin
                            w_state_nxt = RD_IDLE;
                        end
                    end else begin
                        w_x_nxt   = r_x + WADDR_W'(1);
                        w_re      = 1'b1;
                        w_rd_addr = r_x + WADDR_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = RD_IDLE;
            end
        endcase
    end

    assign w_valid_nxt = (w_state_nxt == RD_STREAM);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= RD_IDLE;
            r_pass      <= 1'b0;
            r_x         <= '0;
            r_rd_len    <= '0;
            r_rd_bank   <= 1'b0;
            r_rd_sof    <= 1'b0;
            r_out_valid <= 1'b0;
            r_sol       <= 1'b0;
            r_eol       <= 1'b0;
            r_sof       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pass      <= w_pass_nxt;
            r_x         <= w_x_nxt;
            if (w_handoff) begin
                r_rd_bank <= r_wr_bank;
                r_rd_len  <= r_wr_x;
                r_rd_sof  <= r_frame_pending;
            end
            r_out_valid <= w_valid_nxt;
            r_sol       <= w_valid_nxt & (w_x_nxt == '0);
            r_eol       <= w_valid_nxt & ({1'b0, w_x_nxt} == (r_rd_len - LEN_W'(1)));
            r_sof       <= w_valid_nxt & r_rd_sof & ~w_pass_nxt & (w_x_nxt == '0);
        end
    end

`ifdef SCANLINE_DIM_EN
    assign w_pix = r_pass ? rgb_dim(w_rd_data) : w_rd_data;
`else
    assign w_pix = w_rd_data;
`endif

    assign out_valid  = r_out_valid;
    assign out_r      = w_pix.r;
    assign out_g      = w_pix.g;
    assign out_b      = w_pix.b;
    assign out_sol    = r_sol;
    assign out_eol    = r_eol;
    assign out_sof    = r_sof;
    assign overflow   = r_overflow;
    assign line_width = r_line_width;

endmodule

// File: tb/tb_vce_line_doubler.sv
// Bench for vce_line_doubler: line-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_vce_line_doubler;

    localparam int unsigned MAXW = 512;
    localparam int unsigned PW   = 8;
    localparam int unsigned LW   = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          pix_valid = 1'b0;
    logic [PW-1:0] vid_r = '0, vid_g = '0, vid_b = '0;
    logic          hsync_n = 1'b1, vsync_n = 1'b1;
    logic          out_ready = 1'b0;
    logic          out_valid, out_sol, out_eol, out_sof, overflow;
    logic [PW-1:0] out_r, out_g, out_b;
    logic [LW-1:0] line_width;

    always #5 clock = ~clock;

    vce_line_doubler dut (
        .clock      (clock),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .vid_r      (vid_r),
        .vid_g      (vid_g),
        .vid_b      (vid_b),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b),
        .out_sol    (out_sol),
        .out_eol    (out_eol),
        .out_sof    (out_sof),
        .overflow   (overflow),
        .line_width (line_width)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rdy_mode = 0;   // 0 hold, 1 toggle, 2 random

    // Reference model: a write buffer, a latched line and a replay cursor
    logic [23:0] m_wbuf [MAXW];
    logic [23:0] m_line [MAXW];
    int m_wx, m_len, m_x, m_gap, m_lw;
    bit m_busy, m_pass, m_sof, m_fp, m_ovf, m_hs_prev, m_vs_prev;

    logic [23:0] px_src [MAXW];

    typedef struct {
        logic [23:0] pix;
        bit          sol;
        bit          eol;
        bit          sof;
        int          c;
    } xfer_t;
    xfer_t log_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic m_reset();
        m_wx = 0; m_len = 1; m_x = 0; m_gap = 0; m_lw = 0;
        m_busy = 0; m_pass = 0; m_sof = 0; m_fp = 1; m_ovf = 0;
        m_hs_prev = 1; m_vs_prev = 1;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled
    task automatic m_step();
        bit hs_fall, vs_fall, was_busy;
        if (reset) begin
            m_reset();
            return;
        end
        hs_fall  = m_hs_prev && !hsync_n;
        vs_fall  = m_vs_prev && !vsync_n;
        was_busy = m_busy;
        if (m_busy) begin
            if (m_gap > 0) m_gap--;
            else if (out_ready) begin
                if (m_x == m_len - 1) begin
                    if (!m_pass) begin
                        m_pass = 1; m_x = 0; m_gap = 1;
                    end else begin
                        m_busy = 0;
                    end
                end else begin
                    m_x++;
                end
            end
        end
        if (vs_fall) begin
            m_wx = 0; m_fp = 1;
        end else if (hs_fall && m_wx > 0) begin
            if (!was_busy) begin
                for (int i = 0; i < m_wx; i++) m_line[i] = m_wbuf[i];
                m_len = m_wx; m_lw = m_wx; m_sof = m_fp; m_fp = 0;
                m_busy = 1; m_pass = 0; m_x = 0; m_gap = 1;
            end else begin
                m_ovf = 1;
            end
            m_wx = 0;
        end else if (pix_valid && hsync_n && vsync_n && m_wx < MAXW) begin
            m_wbuf[m_wx] = {vid_r, vid_g, vid_b};
            m_wx++;
        end
        m_hs_prev = hsync_n;
        m_vs_prev = vsync_n;
    endtask

    task automatic m_compare();
        bit ev;
        logic [23:0] ep;
        ev = m_busy && (m_gap == 0);
        chk("out_valid", out_valid, ev);
        if (ev) begin
            ep = m_line[m_x];
`ifdef SCANLINE_DIM_EN
            if (m_pass) ep = {1'b0, ep[23:17], 1'b0, ep[15:9], 1'b0, ep[7:1]};
`endif
            chk("pixel", {out_r, out_g, out_b}, ep);
            chk("sol", out_sol, m_x == 0);
            chk("eol", out_eol, m_x == m_len - 1);
            chk("sof", out_sof, m_sof && !m_pass && m_x == 0);
        end
        chk("overflow", overflow, m_ovf);
        chk("line_width", line_width, m_lw);
    endtask

    task automatic tick();
        case (rdy_mode)
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
        if (out_valid === 1'b1 && out_ready)
            log_q.push_back('{{out_r, out_g, out_b}, out_sol, out_eol, out_sof, cyc});
        m_step();
        @(posedge clock);
        @(negedge clock);
        cyc++;
        m_compare();
    endtask

    task automatic idle(input int n);
        pix_valid = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vsync_pulse();
        pix_valid = 0;
        vsync_n = 0; tick(); tick();
        vsync_n = 1; tick();
    endtask

    // Send n pixels (from px_src or random), optionally with gaps, then an hsync pulse
    task automatic send_line(input int n, input bit rnd, input bit gaps, input bit do_hs);
        int sent = 0;
        logic [23:0] p;
        while (sent < n) begin
            pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            p = rnd ? 24'($urandom) : px_src[sent % MAXW];
            {vid_r, vid_g, vid_b} = p;
            tick();
            if (pix_valid) sent++;
        end
        pix_valid = 0;
        if (do_hs) begin
            hsync_n = 0;
            pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            tick(); tick();
            hsync_n = 1; pix_valid = 0;
            tick();
        end
    endtask

    initial begin
        m_reset();
        reset = 1;
        tick(); tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_rgb", {out_r, out_g, out_b}, 0);
        chk("rst_markers", {out_sol, out_eol, out_sof}, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_width", line_width, 0);
        reset = 0;
        tick();

        // Four-pixel line after vsync, ready held high
        out_ready = 1; rdy_mode = 0;
        px_src[0] = 24'h010203; px_src[1] = 24'h040506;
        px_src[2] = 24'h070809; px_src[3] = 24'h0A0B0C;
        vsync_pulse();
        log_q.delete();
        send_line(4, 0, 0, 1);
        idle(20);
        chk("d1_count", log_q.size(), 8);
        if (log_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("d1_pix", log_q[i].pix, px_src[i % 4]);
                chk("d1_sof", log_q[i].sof, i == 0);
                chk("d1_sol", log_q[i].sol, (i % 4) == 0);
                chk("d1_eol", log_q[i].eol, (i % 4) == 3);
            end
            chk("d1_no_bubble", log_q[1].c - log_q[0].c, 1);
            chk("d1_one_bubble", log_q[4].c - log_q[3].c, 2);
        end
        chk("d1_width", line_width, 4);

        // Same line, ready toggling
        rdy_mode = 1;
        log_q.delete();
        send_line(4, 0, 0, 1);
        idle(40);
        chk("d2_count", log_q.size(), 8);
        if (log_q.size() == 8)
            for (int i = 0; i < 8; i++) chk("d2_pix", log_q[i].pix, px_src[i % 4]);

        // Ready low: A handed off, B and C dropped
        rdy_mode = 0; out_ready = 0;
        idle(4);
        log_q.delete();
        px_src[0] = 24'hA00001; px_src[1] = 24'hA00002; px_src[2] = 24'hA00003;
        send_line(3, 0, 0, 1);
        px_src[0] = 24'hB00001; px_src[1] = 24'hB00002; px_src[2] = 24'hB00003;
        send_line(3, 0, 0, 1);
        px_src[0] = 24'hC00001; px_src[1] = 24'hC00002; px_src[2] = 24'hC00003;
        send_line(3, 0, 0, 1);
        chk("d3_overflow", overflow, 1);
        out_ready = 1;
        idle(20);
        chk("d3_count", log_q.size(), 6);
        if (log_q.size() == 6)
            for (int i = 0; i < 6; i++) chk("d3_pix", log_q[i].pix, 24'hA00001 + 24'(i % 3));

        // Over-long line is truncated to MAX_WIDTH
        log_q.delete();
        send_line(600, 1, 0, 1);
        idle(1100);
        chk("d4_width", line_width, MAXW);
        chk("d4_count", log_q.size(), 1024);
        if (log_q.size() == 1024) begin
            chk("d4_eol511", log_q[511].eol, 1);
            chk("d4_eol510", log_q[510].eol, 0);
            chk("d4_sol512", log_q[512].sol, 1);
            chk("d4_eol1023", log_q[1023].eol, 1);
        end

        // Reset during pass 0
        log_q.delete();
        send_line(8, 1, 0, 1);
        for (int k = 0; k < 30 && log_q.size() < 2; k++) tick();
        chk("d5_started", log_q.size() >= 2, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("d5_valid", out_valid, 0);
        chk("d5_overflow", overflow, 0);
        tick();
        log_q.delete();
        vsync_pulse();
        send_line(3, 1, 0, 1);
        idle(20);
        chk("d5_count", log_q.size(), 6);
        if (log_q.size() == 6) chk("d5_sof", log_q[0].sof, 1);

        // Single-pixel line: dimming and sol/eol together
        log_q.delete();
        px_src[0] = 24'hFF8001;
        send_line(1, 0, 0, 1);
        idle(12);
        chk("d6_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("d6_p0", log_q[0].pix, 24'hFF8001);
`ifdef SCANLINE_DIM_EN
            chk("d6_p1", log_q[1].pix, 24'h7F4000);
`else
            chk("d6_p1", log_q[1].pix, 24'hFF8001);
`endif
            chk("d6_soleol", {log_q[0].sol, log_q[0].eol, log_q[1].sol, log_q[1].eol}, 4'hF);
        end

        // Randomized traffic with random backpressure
        rdy_mode = 2;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 7) == 0) vsync_pulse();
            if ($urandom_range(0, 9) == 0) begin
                send_line($urandom_range(1, 10), 1, 1, 0);
                vsync_pulse();
            end else begin
                send_line($urandom_range(1, 24), 1, 1, 1);
            end
            idle($urandom_range(0, 30));
        end
        rdy_mode = 0; out_ready = 1;
        idle(120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vce_line_doubler.md
Name: vce_line_doubler

Overview:
- Sits directly downstream of vce_HuC6260 and consumes its VIDEO_R/G/B and sync outputs.
- Captures each active VCE scanline into a ping-pong line buffer and replays it twice (vertical 2x) as a valid/ready pixel stream, with start-of-line, end-of-line and start-of-frame markers, for the HD output path.
- Lines that arrive while the replay side is still busy are dropped and flagged.

Parameters:
- MAX_WIDTH, 512, maximum pixels stored per line; longer lines are truncated.
- PIXEL_W, 8, bits per colour channel.
- Derived: WADDR_W = $clog2(MAX_WIDTH); LEN_W = WADDR_W+1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  VCE pixel strobe; one pixel per asserted cycle.
- vid_r, vid_g, vid_b  in  PIXEL_W each  VCE colour.
- hsync_n  in  1  VCE horizontal sync, active low.
- vsync_n  in  1  VCE vertical sync, active low.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accept.
- out_r, out_g, out_b  out  PIXEL_W each  output colour.
- out_sol  out  1  first pixel of each replayed pass.
- out_eol  out  1  last pixel of each replayed pass.
- out_sof  out  1  first pixel of the first line after vsync.
- overflow  out  1  sticky: a completed line was dropped.
- line_width  out  LEN_W  pixel count of the last line handed off.

Behaviour:
- Reset:
  - out_valid, out_r/g/b, out_sol/eol/sof, overflow and line_width all 0.
  - Writer bank 0, wr_x=0, reader IDLE, frame_pending=1.
  - Buffer contents are don't-care.
  - Reset mid-line or mid-replay abandons everything within 1 cycle.
- Edge detect: hs_prev/vs_prev are registered copies of the syncs. hs_fall = hs_prev & ~hsync_n; vs_fall likewise, same cycle.
- Writer:
  - When pix_valid & hsync_n & vsync_n: write the pixel to wr_bank[wr_x] if wr_x<MAX_WIDTH.
  - wr_x increments, saturating at MAX_WIDTH; excess pixels are discarded.
  - A pixel coincident with a sync-low cycle is discarded.
- vs_fall: wr_x<=0 (partial line discarded); frame_pending<=1.
- hs_fall with wr_x==0: ignored.
- hs_fall with wr_x>0:
  - Reader IDLE in that cycle (hand-off): rd_bank<=wr_bank, rd_len<=wr_x, line_width<=wr_x, rd_sof<=frame_pending, frame_pending<=0, wr_bank flips, wr_x<=0, reader->FETCH with pass=0.
  - Reader not IDLE (drop): overflow<=1, wr_x<=0, bank does not flip.
  - A reader completing its final transfer in the same cycle counts as busy, so the line is dropped.
- vs_fall and hs_fall in the same cycle: the vs_fall rule wins (no hand-off).
- Reader FSM states: IDLE, FETCH, STREAM.
  - FETCH issues a read of address 0. The buffer has 1-cycle synchronous read latency.
  - STREAM: out_valid=1. out_sol=(x==0). out_eol=(x==rd_len-1). out_sof=(rd_sof & pass==0 & x==0).
  - While out_valid & ~out_ready, all out_* hold stable.
  - On each transfer the next address is prefetched. With out_ready held high, each pass streams one pixel per cycle with no bubbles.
  - The last transfer of pass 0 sets pass=1, x=0, ->FETCH (exactly 1 bubble).
  - The last transfer of pass 1 -> IDLE, with out_valid=0 in the next cycle.
- Latency: out_valid rises 2 cycles after the hand-off cycle.
- rd_len==1: sol and eol are both asserted on the single pixel of each pass.
- overflow clears only on reset.

Optional Feature:
- Macro: SCANLINE_DIM_EN.
- Defined: pass 1 outputs each channel as the stored value >>1 (logical shift, floor); pass 0 is unchanged.
- Undefined: both passes are identical to the stored pixels.

Decomposition:
- Shared package pce_video_pkg:
  - rgb_t packed struct {r,g,b} of PIXEL_W each.
  - Reader-state enum.
  - Default constants for MAX_WIDTH and PIXEL_W.
- Sub-module line_bank_ram:
  - 2 x MAX_WIDTH x rgb_t storage.
  - One write port (bank, addr, data, we) and one synchronous read port (bank, addr); read-during-write to the other bank is legal.

Test Plan:
- Single line after vsync, 4 px = 0x010203, 0x040506, 0x070809, 0x0A0B0C, out_ready=1 -> 8 transfers (p0..p3, p0..p3); sof on transfer 0 only; sol on transfers 0 and 4; eol on 3 and 7; line_width=4; 1 bubble between passes.
- Same line with out_ready toggling 1,0,1,0 -> out_* stable on every valid & ~ready cycle; exactly 8 transfers with no loss or duplication.
- out_ready=0; send line A (3 px), then lines B and C (3 px each) -> A handed off, B and C dropped, overflow=1; after out_ready=1, output is A twice (6 transfers) only.
- MAX_WIDTH=512, line of 600 px -> line_width=512; 1024 transfers; eol on transfers 511 and 1023.
- Assert reset for 1 cycle during pass 0 of a line -> next cycle out_valid=0, overflow=0; the following vsync and line stream normally with sof=1.
- With SCANLINE_DIM_EN, pixel {0xFF,0x80,0x01} -> pass 0 is {0xFF,0x80,0x01}, pass 1 is {0x7F,0x40,0x00}; without the macro both passes are identical.
